// File: rtl/dot_product_stream_if.sv
// Handshake and operand bundle for dot_product_stream.
// master drives requests/operands; slave is the accumulator block.
interface dot_product_stream_if #(
  parameter int ELEM_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int LEN_WIDTH    = 5,
  parameter int RESULT_WIDTH = 24
);
  localparam int DATA_WIDTH = LANES * ELEM_WIDTH;

  logic                    start;
  logic [LEN_WIDTH-1:0]    vec_len;
  logic                    signed_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_a;
  logic [DATA_WIDTH-1:0]   in_b;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy;
  logic                    overflow;

  modport master (
    output start, vec_len, signed_mode, in_valid, in_a, in_b, result_ready,
    input  in_ready, result, result_valid, busy, overflow
  );

  modport slave (
    input  start, vec_len, signed_mode, in_valid, in_a, in_b, result_ready,
    output in_ready, result, result_valid, busy, overflow
  );
endinterface

// File: rtl/dot_product_stream.sv
// Streaming dot product: LANES products per beat registered in stage 1,
// summed into a modular accumulator in stage 2, with sticky range overflow.
module dot_product_stream #(
  parameter int ELEM_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int MAX_WORDS    = 16,
  parameter int LEN_WIDTH    = 5,
  parameter int RESULT_WIDTH = 24
) (
  input logic                 clk,
  input logic                 rst_n,
  dot_product_stream_if.slave bus
);
  localparam int PROD_W = 2 * ELEM_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
  localparam int EXT_W  = ((RESULT_WIDTH > SUM_W) ? RESULT_WIDTH : SUM_W) + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                  state, state_d;
  logic [LEN_WIDTH-1:0]    len_q, count, count_inc, len_clamp;
  logic                    sign_q;
  logic                    fire;
  logic                    s1_valid;
  logic [PROD_W-1:0]       prod_q [LANES];
  logic [PROD_W-1:0]       prod_d [LANES];
  logic [RESULT_WIDTH-1:0] acc;
  logic                    ovf;
  logic [EXT_W-1:0]        lane_sum, acc_ext, sum_ext;
  logic [EXT_W-RESULT_WIDTH:0] sum_top;
  logic                    step_ovf;

  function automatic logic [PROD_W-1:0] ext_elem(input logic [ELEM_WIDTH-1:0] v, input logic s);
    return {{ELEM_WIDTH{s & v[ELEM_WIDTH-1]}}, v};
  endfunction

  function automatic logic [EXT_W-1:0] ext_prod(input logic [PROD_W-1:0] p, input logic s);
    return {{(EXT_W-PROD_W){s & p[PROD_W-1]}}, p};
  endfunction

  assign fire      = bus.in_valid && (state == ACCUM);
  assign count_inc = count + LEN_WIDTH'(1);
  assign len_clamp = (bus.vec_len > LEN_WIDTH'(MAX_WORDS)) ? LEN_WIDTH'(MAX_WORDS) : bus.vec_len;

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      prod_d[k] = ext_elem(bus.in_a[k*ELEM_WIDTH +: ELEM_WIDTH], sign_q)
                * ext_elem(bus.in_b[k*ELEM_WIDTH +: ELEM_WIDTH], sign_q);
    end
  end

  // Overflow is judged on the wrapped accumulator: until the first overflow it
  // equals the exact sum, and afterwards the flag is sticky anyway.
  always_comb begin
    lane_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + ext_prod(prod_q[k], sign_q);
    end
    acc_ext  = {{(EXT_W-RESULT_WIDTH){sign_q & acc[RESULT_WIDTH-1]}}, acc};
    sum_ext  = acc_ext + lane_sum;
    sum_top  = sum_ext[EXT_W-1:RESULT_WIDTH-1];
    step_ovf = sign_q ? !((&sum_top) || (~|sum_top))
                      : (|sum_top[EXT_W-RESULT_WIDTH:1]);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = (bus.vec_len == '0) ? DONE : ACCUM;
      ACCUM:   if (fire && (count_inc == len_q)) state_d = DRAIN;
      DRAIN:   if (!s1_valid) state_d = DONE;
      DONE:    if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      sign_q   <= 1'b0;
      count    <= '0;
      s1_valid <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        count <= count_inc;
        for (int unsigned k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
      end
      if ((state == IDLE) && bus.start) begin
        len_q  <= len_clamp;
        sign_q <= bus.signed_mode;
        count  <= '0;
        acc    <= '0;
        ovf    <= 1'b0;
      end else if (s1_valid) begin
        acc <= sum_ext[RESULT_WIDTH-1:0];
        ovf <= ovf | step_ovf;
      end
    end
  end

  assign bus.in_ready     = (state == ACCUM);
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = acc;
  assign bus.overflow     = ovf;
endmodule
